// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_unit_pkg : shared widths, reset PC and fetch FSM encoding
// Revision: 1.0
// ============================================================================
package fetch_unit_pkg;

  localparam int unsigned INSTR_W          = 10;
  localparam logic [7:0]  RESET_PC_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : prefetch buffer of {instruction, pc} entries with flush
// Revision: 1.0
// ============================================================================
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is legal only when the head leaves the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC owner, instruction ROM reader and prefetch buffer feeding
//              the decoder; handles redirect (flush) and halt
// Revision: 1.0
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Enable,
  output logic               ImemRe,
  output logic [ADDR_W-1:0]  ImemAddr,
  input  logic [INSTR_W-1:0] ImemData,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPc,
  input  logic               Halt,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  InstrPc,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [ADDR_W-1:0]  Pc
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [ADDR_W-1:0]  issued_pc;
  logic               inflight;
  logic               issue;
  logic               pop;
  logic               push;
  logic               flush;
  logic               kill;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;

  // Redirect only flushes once fetching has started; in IDLE it just loads the PC
  assign flush = Redirect && (state != ST_IDLE);
  assign pop   = !empty && InstrReady;

  // The head leaving this cycle frees a slot, which sustains one word per cycle
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign issue     = (state == ST_RUN) && !Redirect && !Halt &&
                     (!full || pop) && (occupancy < (CNT_W+1)'(DEPTH));

  // The inflight word returns on the same edge the flush takes effect
  assign kill = flush && inflight;
  assign push = inflight && !kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    case (state)
      ST_IDLE: begin
        if (Enable) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Halt && !Redirect) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (Redirect) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (Redirect) begin
      pc_nxt = RedirectPc;
    end else if (issue) begin
      pc_nxt = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      inflight  <= 1'b0;
      issued_pc <= '0;
    end else begin
      pc_q     <= pc_nxt;
      inflight <= issue;
      if (issue) begin
        issued_pc <= pc_q;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({ImemData, issued_pc}),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign ImemRe      = issue;
  assign ImemAddr    = issue ? pc_q : '0;
  assign Pc          = pc_q;
  assign InstrValid  = !empty;
  assign Instruction = head[ENTRY_W-1:ADDR_W];
  assign InstrPc     = head[ADDR_W-1:0];

endmodule
`default_nettype wire
